rv0_alu_md: RTL and testbench

Iterative integer multiply/divide unit executing all eight RV M-extension operations for a parametrised XLEN (32 or 64).
Sits beside the single-cycle integer ALU in the execute stage and is selected for OP/OP-32 with funct7=0000001.
Operands and a tag are accepted over a valid/ready request channel; the result is returned over a valid/ready response channel.
A flush input kills in-flight work on pipeline redirect.

---
 rtl/rv0_alu_md.sv | 229 ++++++++++++++++++++++
 tb/tb_rv0_alu_md.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv0_alu_md.sv
// rv0_alu_md -- iterative RV M-extension multiply/divide unit.
//
// Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on XLEN-bit
// operands. Multiplies use radix-2 shift-add and divides use radix-2
// restoring division, one bit per cycle, on unsigned magnitudes. The sign
// is restored when the result is registered. Divide-by-zero and signed
// overflow (min / -1) bypass the iterative datapath and answer in one cycle.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   flush           synchronous kill of any in-flight or pending result
//   req_valid/ready request handshake; req_op is funct3,
//                   req_rs1/req_rs2 are operands, req_tag is carried through
//   res_valid/ready response handshake; res_data/res_tag are registered
//                   and held stable while res_valid && !res_ready
module rv0_alu_md #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic                neg_q;   // negate product / quotient
  logic                neg_r;   // negate remainder (dividend sign)
  logic [XLEN-1:0]     opd;     // multiplicand (mul) or divisor (div) magnitude
  // Shared work register. Multiply: {partial product high, multiplier}.
  // Divide: {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic            is_div;
  logic            signed_a;
  logic            signed_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = req_op[2];
    // MUL/MULH/MULHSU: rs1 signed; DIV/REM: both signed
    signed_a = is_div ? !req_op[0] : (req_op[1:0] != 2'b11);
    // MUL/MULH/DIV/REM: rs2 signed
    signed_b = is_div ? !req_op[0] : !req_op[1];
    a_neg    = signed_a && req_rs1[XLEN-1];
    b_neg    = signed_b && req_rs2[XLEN-1];
    a_mag    = a_neg ? -req_rs1 : req_rs1;
    b_mag    = b_neg ? -req_rs2 : req_rs2;

    div_zero = is_div && (req_rs2 == '0);
    div_ovf  = is_div && !req_op[0] && (req_rs1 == MIN_NEG) && (req_rs2 == '1);

    special_res = '0;
    if (div_zero) begin
      // quotient all-ones, remainder is the dividend
      special_res = req_op[1] ? req_rs1 : '1;
    end else if (div_ovf) begin
      // quotient is the dividend (min), remainder zero
      special_res = req_op[1] ? '0 : req_rs1;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right. The
    // carry out of the add becomes the new top bit.
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd};
    mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                      : {1'b0, acc[2*XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder,
    // trial-subtract the divisor, keep the difference if it did not borrow.
    // The partial remainder is always below the divisor, so XLEN+1 bits
    // hold the shifted value and the sign of the difference is exact.
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opd};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    acc_next = op_q[2] ? div_next : mul_next;
  end

  // ---------------------------------------------------------------------
  // Result selection with sign fixup, applied to the final step's value
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod_fix = neg_q ? -acc_next : acc_next;
    quo      = acc_next[XLEN-1:0];
    rem      = acc_next[2*XLEN-1:XLEN];
    final_res = '0;
    case (op_q)
      OP_MUL:                      final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = neg_q ? -quo : quo;
      OP_REM, OP_REMU:             final_res = neg_r ? -rem : rem;
      default:                     final_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      opd       <= '0;
      acc       <= '0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            tag_q     <= req_tag;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            req_ready <= 1'b0;
            if (div_zero || div_ovf) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= special_res;
              res_tag   <= req_tag;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(XLEN);
              opd   <= is_div ? b_mag : a_mag;
              acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            end
          end
        end

        BUSY: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= final_res;
            res_tag   <= tag_q;
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv0_alu_md.sv
// tb_rv0_alu_md -- self-checking bench for rv0_alu_md at XLEN=32.
// Table of directed vectors with hand-computed results and latencies,
// plus hand-written back-pressure, flush and reset-abort sequences.
module tb_rv0_alu_md;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_tag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;

  int n_tests = 0;
  int n_fail  = 0;

  rv0_alu_md #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, measure edges until res_valid (accept edge counts as 1),
  // check result, then complete the handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat_exp,
                        input string nm);
    int lat;
    check({nm, " ready_before"}, 64'(req_ready), 64'd1);
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(lat_exp));
    check({nm, " data"}, 64'(res_data), 64'(exp));
    check({nm, " tag"}, 64'(res_tag), 64'(tag));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({nm, " valid_after_hs"}, 64'(res_valid), 64'd0);
    check({nm, " ready_after_hs"}, 64'(req_ready), 64'd1);
  endtask

  // Watch for any res_valid over a window; expect none.
  task automatic expect_silent(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;

    // op   rs1           rs2           expected      latency
    vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33}); // MUL 7*-3
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33}); // MULH
    vecs.push_back('{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33}); // MULHU
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33}); // MULHSU -1*(2^32-1)
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33}); // DIV -7/2
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33}); // REM -7%2
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       33}); // DIVU
    vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        33}); // REMU
    vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});  // DIV /0
    vecs.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        1});  // REMU /0
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});  // DIV ovf
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});  // REM ovf
    vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});  // DIVU /0
    vecs.push_back('{3'b110, 32'd9,        32'd0,        32'd9,        1});  // REM /0
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33}); // MULHU max*max
    vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33}); // MUL -1*-1
    vecs.push_back('{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 33}); // MULH max+^2
    vecs.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33}); // MULHSU min*(2^32-1)
    vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33}); // DIV 7/-2
    vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33}); // REM 7%-2
    vecs.push_back('{3'b100, 32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 33}); // DIV -8/3
    vecs.push_back('{3'b110, 32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 33}); // REM -8%3
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33}); // DIVU max/1
    vecs.push_back('{3'b100, 32'h80000000, 32'd1,        32'h80000000, 33}); // DIV min/1

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_tag   = '0;
    res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_data",  64'(res_data),  64'd0);
    check("reset res_tag",   64'(res_tag),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table; first vector uses tag 5.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0) ? 5'd5 : 5'(i),
             vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-pressure: hold result for 10 cycles in DONE.
    req_op = 3'b101; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd9;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp valid c%0d", i), 64'(res_valid), 64'd1);
      check($sformatf("bp data c%0d", i),  64'(res_data),  64'd14);
      check($sformatf("bp tag c%0d", i),   64'(res_tag),   64'd9);
      check($sformatf("bp req_ready c%0d", i), 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp valid after hs", 64'(res_valid), 64'd0);
    check("bp req_ready after hs", 64'(req_ready), 64'd1);

    // Flush at BUSY cycle 10.
    req_op = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd4; req_tag = 5'd17;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("flush busy req_ready", 64'(req_ready), 64'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush req_ready", 64'(req_ready), 64'd1);
    check("flush res_valid", 64'(res_valid), 64'd0);
    expect_silent("flush no response", 40);

    // Flush in DONE while res_ready: no handshake, back to IDLE.
    req_op = 3'b100; req_rs1 = 32'd1; req_rs2 = 32'd0; req_tag = 5'd21;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("flushdone valid", 64'(res_valid), 64'd1);
    flush = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; res_ready = 1'b0;
    check("flushdone res_valid", 64'(res_valid), 64'd0);
    check("flushdone req_ready", 64'(req_ready), 64'd1);

    // Flush coincident with req_valid in IDLE: request must be dropped.
    req_op = 3'b100; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd22;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush+req req_ready", 64'(req_ready), 64'd1);
    expect_silent("flush+req no response", 5);

    // Recovery after flush.
    run_op(3'b000, 32'd6, 32'd7, 5'd3, 32'd42, 33, "post_flush");

    // Reset mid-BUSY: outputs return to reset values without a clock edge.
    req_op = 3'b000; req_rs1 = 32'd11; req_rs2 = 32'd13; req_tag = 5'd30;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("rst mid req_ready", 64'(req_ready), 64'd1);
    check("rst mid res_valid", 64'(res_valid), 64'd0);
    check("rst mid res_data",  64'(res_data),  64'd0);
    check("rst mid res_tag",   64'(res_tag),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_silent("rst mid no response", 40);

    run_op(3'b111, 32'd23, 32'd5, 5'd4, 32'd3, 33, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got simulation time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
